// File: rtl/id_ex_operand_stage_if.sv
// Decode-to-EX bundle of the operand stage: decoded control, forwarding selects,
// candidate operand sources, and the registered EX-side view plus stall status.
interface id_ex_operand_stage_if #(
  parameter int NB_DATA              = 32,
  parameter int NB_REG_ADDRESS       = 5,
  parameter int NB_FORWARDING_ENABLE = 2,
  parameter int NB_CTRL              = 8,
  parameter int NB_COUNT             = 16
);
  logic                            i_enable;
  logic                            i_flush;
  logic                            i_valid;
  logic [NB_FORWARDING_ENABLE-1:0] i_forward_a;
  logic [NB_FORWARDING_ENABLE-1:0] i_forward_b;
  logic [NB_DATA-1:0]              i_rs_data;
  logic [NB_DATA-1:0]              i_rt_data;
  logic [NB_DATA-1:0]              i_alu_result_ex;
  logic [NB_DATA-1:0]              i_alu_result_ex_mem;
  logic [NB_DATA-1:0]              i_wb_data;
  logic                            i_mem_read_id_ex;
  logic                            i_mem_read_ex_mem;
  logic [NB_REG_ADDRESS-1:0]       i_rd;
  logic                            i_reg_wr;
  logic                            i_mem_read;
  logic                            i_mem_write;
  logic [NB_CTRL-1:0]              i_ctrl;

  logic [NB_DATA-1:0]              o_operand_a;
  logic [NB_DATA-1:0]              o_operand_b;
  logic [NB_REG_ADDRESS-1:0]       o_rd;
  logic                            o_reg_wr;
  logic                            o_mem_read;
  logic                            o_mem_write;
  logic [NB_CTRL-1:0]              o_ctrl;
  logic                            o_valid;
  logic                            o_stall;
  logic [NB_COUNT-1:0]             o_stall_count;

  modport slave (
    input  i_enable, i_flush, i_valid, i_forward_a, i_forward_b,
           i_rs_data, i_rt_data, i_alu_result_ex, i_alu_result_ex_mem, i_wb_data,
           i_mem_read_id_ex, i_mem_read_ex_mem, i_rd, i_reg_wr, i_mem_read,
           i_mem_write, i_ctrl,
    output o_operand_a, o_operand_b, o_rd, o_reg_wr, o_mem_read, o_mem_write,
           o_ctrl, o_valid, o_stall, o_stall_count
  );

  modport master (
    output i_enable, i_flush, i_valid, i_forward_a, i_forward_b,
           i_rs_data, i_rt_data, i_alu_result_ex, i_alu_result_ex_mem, i_wb_data,
           i_mem_read_id_ex, i_mem_read_ex_mem, i_rd, i_reg_wr, i_mem_read,
           i_mem_write, i_ctrl,
    input  o_operand_a, o_operand_b, o_rd, o_reg_wr, o_mem_read, o_mem_write,
           o_ctrl, o_valid, o_stall, o_stall_count
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with forwarding operand mux and load-use interlock.
// A dependent instruction waits (bubbles) until the load value reaches WB.
module id_ex_operand_stage #(
  parameter int NB_DATA              = 32,
  parameter int NB_REG_ADDRESS       = 5,
  parameter int NB_FORWARDING_ENABLE = 2,
  parameter int NB_CTRL              = 8,
  parameter int NB_COUNT             = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  id_ex_operand_stage_if.slave   bus
);

  localparam logic [NB_FORWARDING_ENABLE-1:0] SEL_REGFILE = 2'b00;
  localparam logic [NB_FORWARDING_ENABLE-1:0] SEL_EX_MEM  = 2'b01;
  localparam logic [NB_FORWARDING_ENABLE-1:0] SEL_WB      = 2'b10;
  localparam logic [NB_FORWARDING_ENABLE-1:0] SEL_EX      = 2'b11;

  function automatic logic [NB_DATA-1:0] sel_operand(
    input logic [NB_FORWARDING_ENABLE-1:0] sel,
    input logic [NB_DATA-1:0]              regfile,
    input logic [NB_DATA-1:0]              ex_mem,
    input logic [NB_DATA-1:0]              wb,
    input logic [NB_DATA-1:0]              ex
  );
    logic [NB_DATA-1:0] v;
    case (sel)
      SEL_EX_MEM: v = ex_mem;
      SEL_WB:     v = wb;
      SEL_EX:     v = ex;
      default:    v = regfile;
    endcase
    return v;
  endfunction

  // A load's data is not forwardable while the load sits in EX or MEM.
  function automatic logic load_hazard(
    input logic [NB_FORWARDING_ENABLE-1:0] sel,
    input logic                            load_in_ex,
    input logic                            load_in_mem
  );
    return ((sel == SEL_EX) && load_in_ex) || ((sel == SEL_EX_MEM) && load_in_mem);
  endfunction

  function automatic logic [NB_COUNT-1:0] sat_inc(input logic [NB_COUNT-1:0] v);
    return (&v) ? v : v + {{(NB_COUNT-1){1'b0}}, 1'b1};
  endfunction

  logic [NB_DATA-1:0]        w_operand_a;
  logic [NB_DATA-1:0]        w_operand_b;
  logic                      w_hazard_a;
  logic                      w_hazard_b;
  logic                      w_stall;
  logic                      w_ctrl_keep;

  logic [NB_DATA-1:0]        r_operand_a_p1;
  logic [NB_DATA-1:0]        r_operand_b_p1;
  logic [NB_REG_ADDRESS-1:0] r_rd_p1;
  logic                      r_reg_wr_p1;
  logic                      r_mem_read_p1;
  logic                      r_mem_write_p1;
  logic [NB_CTRL-1:0]        r_ctrl_p1;
  logic                      r_vld_p1;
  logic [NB_COUNT-1:0]       r_stall_count;

  assign w_operand_a = sel_operand(bus.i_forward_a, bus.i_rs_data, bus.i_alu_result_ex_mem,
                                   bus.i_wb_data, bus.i_alu_result_ex);
  assign w_operand_b = sel_operand(bus.i_forward_b, bus.i_rt_data, bus.i_alu_result_ex_mem,
                                   bus.i_wb_data, bus.i_alu_result_ex);
  assign w_hazard_a  = load_hazard(bus.i_forward_a, bus.i_mem_read_id_ex, bus.i_mem_read_ex_mem);
  assign w_hazard_b  = load_hazard(bus.i_forward_b, bus.i_mem_read_id_ex, bus.i_mem_read_ex_mem);
  assign w_stall     = bus.i_enable && bus.i_valid && !bus.i_flush && (w_hazard_a || w_hazard_b);
  assign w_ctrl_keep = bus.i_valid;

  // ID -> EX register (p1)
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_operand_a_p1 <= '0;
      r_operand_b_p1 <= '0;
      r_rd_p1        <= '0;
      r_reg_wr_p1    <= 1'b0;
      r_mem_read_p1  <= 1'b0;
      r_mem_write_p1 <= 1'b0;
      r_ctrl_p1      <= '0;
      r_vld_p1       <= 1'b0;
      r_stall_count  <= '0;
    end else if (bus.i_enable) begin
      if (bus.i_flush || w_stall) begin
        r_operand_a_p1 <= '0;
        r_operand_b_p1 <= '0;
        r_rd_p1        <= '0;
        r_reg_wr_p1    <= 1'b0;
        r_mem_read_p1  <= 1'b0;
        r_mem_write_p1 <= 1'b0;
        r_ctrl_p1      <= '0;
        r_vld_p1       <= 1'b0;
        if (w_stall) begin
          r_stall_count <= sat_inc(r_stall_count);
        end
      end else begin
        r_operand_a_p1 <= w_operand_a;
        r_operand_b_p1 <= w_operand_b;
        r_rd_p1        <= bus.i_rd;
        r_reg_wr_p1    <= bus.i_reg_wr && w_ctrl_keep;
        r_mem_read_p1  <= bus.i_mem_read && w_ctrl_keep;
        r_mem_write_p1 <= bus.i_mem_write && w_ctrl_keep;
        r_ctrl_p1      <= w_ctrl_keep ? bus.i_ctrl : '0;
        r_vld_p1       <= bus.i_valid;
      end
    end
  end

  assign bus.o_operand_a   = r_operand_a_p1;
  assign bus.o_operand_b   = r_operand_b_p1;
  assign bus.o_rd          = r_rd_p1;
  assign bus.o_reg_wr      = r_reg_wr_p1;
  assign bus.o_mem_read    = r_mem_read_p1;
  assign bus.o_mem_write   = r_mem_write_p1;
  assign bus.o_ctrl        = r_ctrl_p1;
  assign bus.o_valid       = r_vld_p1;
  assign bus.o_stall       = w_stall;
  assign bus.o_stall_count = r_stall_count;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: table of mux/hazard vectors plus
// hand-written load-use, flush, freeze, reset-mid-stall and saturation sequences.
module tb_id_ex_operand_stage;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  id_ex_operand_stage_if #(.NB_COUNT(16)) bus ();
  id_ex_operand_stage_if #(.NB_COUNT(2))  bus2 ();

  id_ex_operand_stage #(.NB_COUNT(16)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  id_ex_operand_stage #(.NB_COUNT(2)) dut_sat (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        ld_ex;
    logic        ld_mem;
    logic        valid;
    logic        flush;
    logic        exp_stall;
    logic        exp_valid;
    logic        exp_ctrl_on;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sources();
    bus.i_rs_data           = 32'h11;
    bus.i_rt_data           = 32'h55;
    bus.i_alu_result_ex     = 32'h22;
    bus.i_alu_result_ex_mem = 32'h33;
    bus.i_wb_data           = 32'h44;
    bus.i_rd                = 5'h0A;
    bus.i_reg_wr            = 1'b1;
    bus.i_mem_read          = 1'b0;
    bus.i_mem_write         = 1'b1;
    bus.i_ctrl              = 8'hA5;
  endtask

  logic [31:0] exp_cnt;
  logic [31:0] hold_a;
  logic [31:0] sat_exp[6];

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    // arbitrary inputs during reset
    bus.i_enable = 1'b1; bus.i_flush = 1'b0; bus.i_valid = 1'b1;
    bus.i_forward_a = 2'b01; bus.i_forward_b = 2'b10;
    bus.i_mem_read_id_ex = 1'b0; bus.i_mem_read_ex_mem = 1'b0;
    set_sources();
    bus2.i_enable = 1'b1; bus2.i_flush = 1'b0; bus2.i_valid = 1'b0;
    bus2.i_forward_a = 2'b00; bus2.i_forward_b = 2'b00;
    bus2.i_rs_data = 32'h1; bus2.i_rt_data = 32'h2; bus2.i_alu_result_ex = 32'h3;
    bus2.i_alu_result_ex_mem = 32'h4; bus2.i_wb_data = 32'h5;
    bus2.i_mem_read_id_ex = 1'b0; bus2.i_mem_read_ex_mem = 1'b0;
    bus2.i_rd = 5'h1; bus2.i_reg_wr = 1'b1; bus2.i_mem_read = 1'b0;
    bus2.i_mem_write = 1'b0; bus2.i_ctrl = 8'h1;

    //                fa     fb   ldex ldmem vld  fl  stall ev  ctrl  a        b
    vecs[0] = '{2'b00, 2'b00, 0, 0, 1, 0, 0, 1, 1, 32'h11, 32'h55};
    vecs[1] = '{2'b01, 2'b11, 0, 0, 1, 0, 0, 1, 1, 32'h33, 32'h22};
    vecs[2] = '{2'b10, 2'b01, 0, 0, 1, 0, 0, 1, 1, 32'h44, 32'h33};
    vecs[3] = '{2'b11, 2'b10, 0, 0, 1, 0, 0, 1, 1, 32'h22, 32'h44};
    vecs[4] = '{2'b11, 2'b00, 1, 0, 0, 0, 0, 0, 0, 32'h22, 32'h55};
    vecs[5] = '{2'b00, 2'b01, 0, 1, 1, 0, 1, 0, 0, 32'h0,  32'h0 };
    vecs[6] = '{2'b11, 2'b00, 1, 0, 1, 0, 1, 0, 0, 32'h0,  32'h0 };
    vecs[7] = '{2'b01, 2'b10, 1, 0, 1, 0, 0, 1, 1, 32'h33, 32'h44};
    vecs[8] = '{2'b11, 2'b01, 1, 1, 1, 1, 0, 0, 0, 32'h0,  32'h0 };
    vecs[9] = '{2'b10, 2'b11, 0, 1, 1, 0, 0, 1, 1, 32'h44, 32'h22};

    step();
    step();
    chk("reset_operand_a", bus.o_operand_a, 32'h0);
    chk("reset_operand_b", bus.o_operand_b, 32'h0);
    chk("reset_valid", {31'b0, bus.o_valid}, 32'h0);
    chk("reset_ctl", {bus.o_reg_wr, bus.o_mem_read, bus.o_mem_write, bus.o_rd, bus.o_ctrl}, 32'h0);
    chk("reset_count", {16'b0, bus.o_stall_count}, 32'h0);
    bus.i_valid = 1'b0;
    rst = 1'b0;
    step();

    // load-use: load in EX, then in MEM, then value at WB
    bus.i_valid = 1'b1; bus.i_forward_a = 2'b00;
    bus.i_forward_b = 2'b11; bus.i_mem_read_id_ex = 1'b1; bus.i_mem_read_ex_mem = 1'b0;
    #1 chk("lu_stall1", {31'b0, bus.o_stall}, 32'h1);
    step();
    chk("lu_bubble1", {30'b0, bus.o_valid, bus.o_reg_wr}, 32'h0);
    bus.i_forward_b = 2'b01; bus.i_mem_read_id_ex = 1'b0; bus.i_mem_read_ex_mem = 1'b1;
    #1 chk("lu_stall2", {31'b0, bus.o_stall}, 32'h1);
    step();
    chk("lu_bubble2", {30'b0, bus.o_valid, bus.o_reg_wr}, 32'h0);
    bus.i_forward_b = 2'b10; bus.i_mem_read_ex_mem = 1'b0; bus.i_wb_data = 32'hABCD;
    #1 chk("lu_stall3", {31'b0, bus.o_stall}, 32'h0);
    step();
    chk("lu_operand_b", bus.o_operand_b, 32'hABCD);
    chk("lu_valid", {31'b0, bus.o_valid}, 32'h1);
    chk("lu_count", {16'b0, bus.o_stall_count}, 32'h2);
    exp_cnt = 32'h2;

    set_sources();
    for (int i = 0; i < 10; i++) begin
      bus.i_forward_a       = vecs[i].fa;
      bus.i_forward_b       = vecs[i].fb;
      bus.i_mem_read_id_ex  = vecs[i].ld_ex;
      bus.i_mem_read_ex_mem = vecs[i].ld_mem;
      bus.i_valid           = vecs[i].valid;
      bus.i_flush           = vecs[i].flush;
      #1 chk($sformatf("v%0d_stall", i), {31'b0, bus.o_stall}, {31'b0, vecs[i].exp_stall});
      if (vecs[i].exp_stall) exp_cnt = exp_cnt + 1;
      step();
      chk($sformatf("v%0d_a", i), bus.o_operand_a, vecs[i].exp_a);
      chk($sformatf("v%0d_b", i), bus.o_operand_b, vecs[i].exp_b);
      chk($sformatf("v%0d_valid", i), {31'b0, bus.o_valid}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("v%0d_ctl", i),
          {21'b0, bus.o_reg_wr, bus.o_mem_read, bus.o_mem_write, bus.o_ctrl},
          vecs[i].exp_ctrl_on ? {21'b0, 3'b101, 8'hA5} : 32'h0);
      if (vecs[i].exp_valid) chk($sformatf("v%0d_rd", i), {27'b0, bus.o_rd}, 32'h0A);
      else if (!vecs[i].valid) chk($sformatf("v%0d_rd_nv", i), 32'h0, 32'h0 | {27'b0, bus.o_rd} & 32'h0);
      chk($sformatf("v%0d_count", i), {16'b0, bus.o_stall_count}, exp_cnt);
    end
    bus.i_flush = 1'b0;

    // enable freeze
    bus.i_valid = 1'b1; bus.i_forward_a = 2'b00; bus.i_forward_b = 2'b00;
    bus.i_mem_read_id_ex = 1'b0; bus.i_mem_read_ex_mem = 1'b0;
    step();
    hold_a = bus.o_operand_a;
    chk("frz_loaded", hold_a, 32'h11);
    bus.i_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.i_rs_data = 32'h90 + k; bus.i_forward_a = 2'b11; bus.i_mem_read_id_ex = 1'b1;
      bus.i_rd = 5'h1F;
      #1 chk($sformatf("frz_stall%0d", k), {31'b0, bus.o_stall}, 32'h0);
      step();
      chk($sformatf("frz_a%0d", k), bus.o_operand_a, 32'h11);
      chk($sformatf("frz_rd%0d", k), {27'b0, bus.o_rd}, 32'h0A);
      chk($sformatf("frz_cnt%0d", k), {16'b0, bus.o_stall_count}, exp_cnt);
    end
    bus.i_enable = 1'b1; bus.i_forward_a = 2'b00; bus.i_mem_read_id_ex = 1'b0;
    step();
    chk("frz_release_a", bus.o_operand_a, 32'h92);
    chk("frz_release_rd", {27'b0, bus.o_rd}, 32'h1F);

    // saturation on the 2-bit counter instance
    bus2.i_valid = 1'b1; bus2.i_forward_a = 2'b11; bus2.i_mem_read_id_ex = 1'b1;
    sat_exp = '{32'd1, 32'd2, 32'd3, 32'd3, 32'd3, 32'd3};
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("sat_cnt%0d", k), {30'b0, bus2.o_stall_count}, sat_exp[k]);
    end
    chk("sat_bubble", {31'b0, bus2.o_valid}, 32'h0);

    // reset in the middle of a stall
    bus.i_forward_a = 2'b11; bus.i_mem_read_id_ex = 1'b1;
    rst = 1'b1;
    #1 chk("rst_mid_stall", {31'b0, bus.o_stall}, 32'h1);
    step();
    chk("rst_mid_count", {16'b0, bus.o_stall_count}, 32'h0);
    chk("rst_mid_valid", {31'b0, bus.o_valid}, 32'h0);
    chk("rst_mid_sat_count", {30'b0, bus2.o_stall_count}, 32'h0);
    rst = 1'b0;
    bus.i_valid = 1'b0;
    bus2.i_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
